board_controller: RTL and testbench



---
 rtl/tictactoe_pkg.sv | 36 +++
 rtl/win_line_check.sv | 18 +
 rtl/board_controller.sv | 97 +++++++++
 tb/tb_board_controller.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tictactoe_pkg.sv
// Shared board encodings, FSM states and the 8-line win table.
// Cell i = row*3+col occupies bits [2i+1:2i] of the 18-bit board vector.
package tictactoe_pkg;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_X     = 2'b01;
   localparam logic [1:0] CELL_O     = 2'b10;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_X    = 2'b01;
   localparam logic [1:0] WIN_O    = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   typedef enum logic [1:0] {READY, SCAN, OVER} state_t;

   typedef logic [3:0] cell_idx_t;

   localparam cell_idx_t LINE_CELLS [8][3] = '{
      '{4'd0, 4'd1, 4'd2},
      '{4'd3, 4'd4, 4'd5},
      '{4'd6, 4'd7, 4'd8},
      '{4'd0, 4'd3, 4'd6},
      '{4'd1, 4'd4, 4'd7},
      '{4'd2, 4'd5, 4'd8},
      '{4'd0, 4'd4, 4'd8},
      '{4'd2, 4'd4, 4'd6}
   };

   // Indices outside 0..8 read as empty so callers need no range guard.
   function automatic logic [1:0] cell_at(input logic [17:0] board, input cell_idx_t idx);
      cell_at = CELL_EMPTY;
      for (int i = 0; i < 9; i++)
         if (idx == cell_idx_t'(i)) cell_at = board[2*i +: 2];
   endfunction

endpackage

// File: rtl/win_line_check.sv
// Combinational test of one board line against the mover's cell code.
// Zero latency; no flow control.
module win_line_check
   import tictactoe_pkg::*;
(
   input  logic [17:0] registers,
   input  logic [2:0]  line,
   input  logic [1:0]  mover,
   output logic        match
);

   always_comb begin
      match = 1'b1;
      for (int k = 0; k < 3; k++)
         if (cell_at(registers, LINE_CELLS[line][k]) != mover) match = 1'b0;
   end

endmodule

// File: rtl/board_controller.sv
// Tic-tac-toe move validation, board update and sequential 8-line win/draw scan.
// Result 1..8 cycles after an accepted move; requests while busy/over are refused with move_err.
module board_controller
   import tictactoe_pkg::*;
#(
   parameter logic FIRST_PLAYER = 1'b0
)(
   input  logic        ph1,
   input  logic        reset,
   input  logic        new_game,
   input  logic        move_valid,
   input  logic [1:0]  move_row,
   input  logic [1:0]  move_col,
   output logic [17:0] registers,
   output logic        turn,
   output logic        busy,
   output logic        move_err,
   output logic        game_over,
   output logic [1:0]  winner
);

   state_t     state;
   logic [3:0] move_count;
   logic [2:0] line;
   logic [1:0] mover;
   logic       match;
   cell_idx_t  target;
   logic       target_ok;

   assign mover     = turn ? CELL_O : CELL_X;
   assign target    = cell_idx_t'(move_row) * 4'd3 + cell_idx_t'(move_col);
   assign target_ok = (move_row != 2'd3) && (move_col != 2'd3) &&
                      (cell_at(registers, target) == CELL_EMPTY);

   win_line_check u_win_line_check (
      .registers (registers),
      .line      (line),
      .mover     (mover),
      .match     (match)
   );

   always_ff @(posedge ph1) begin
      if (reset || new_game) begin
         registers  <= '0;
         turn       <= FIRST_PLAYER;
         busy       <= 1'b0;
         move_err   <= 1'b0;
         game_over  <= 1'b0;
         winner     <= WIN_NONE;
         move_count <= 4'd0;
         line       <= 3'd0;
         state      <= READY;
      end else begin
         move_err <= 1'b0;
         case (state)
            READY: begin
               if (move_valid) begin
                  if (!target_ok) begin
                     move_err <= 1'b1;
                  end else begin
                     registers <= registers | (18'(mover) << {target, 1'b0});
                     if (move_count != 4'd9) move_count <= move_count + 4'd1;
                     line  <= 3'd0;
                     busy  <= 1'b1;
                     state <= SCAN;
                  end
               end
            end
            SCAN: begin
               if (move_valid) move_err <= 1'b1;
               if (match) begin
                  winner    <= mover;
                  game_over <= 1'b1;
                  busy      <= 1'b0;
                  state     <= OVER;
               end else if (line != 3'd7) begin
                  line <= line + 3'd1;
               end else if (move_count == 4'd9) begin
                  winner    <= WIN_DRAW;
                  game_over <= 1'b1;
                  busy      <= 1'b0;
                  state     <= OVER;
               end else begin
                  turn  <= ~turn;
                  busy  <= 1'b0;
                  state <= READY;
               end
            end
            OVER: begin
               if (move_valid) move_err <= 1'b1;
            end
            default: state <= READY;
         endcase
      end
   end

endmodule

// File: tb/tb_board_controller.sv
// Randomized game traffic checked every cycle against a move-level reference model,
// plus directed scenarios with literal expected values.
module tb_board_controller;

   logic        ph1 = 1'b0;
   logic        reset = 1'b1;
   logic        new_game = 1'b0;
   logic        move_valid = 1'b0;
   logic [1:0]  move_row = 2'd0;
   logic [1:0]  move_col = 2'd0;
   logic [17:0] registers;
   logic        turn, busy, move_err, game_over;
   logic [1:0]  winner;

   board_controller #(.FIRST_PLAYER(1'b0)) dut (
      .ph1        (ph1),
      .reset      (reset),
      .new_game   (new_game),
      .move_valid (move_valid),
      .move_row   (move_row),
      .move_col   (move_col),
      .registers  (registers),
      .turn       (turn),
      .busy       (busy),
      .move_err   (move_err),
      .game_over  (game_over),
      .winner     (winner)
   );

   always #5 ph1 = ~ph1;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 0;

   // Reference model: outcome of a move is decided when it is accepted, then
   // released after the number of cycles the line-by-line scan would take.
   int cells [9];
   int m_turn, m_busy, m_err, m_over, m_winner, m_count, m_left, m_outcome;
   int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

   function automatic void m_clear();
      for (int i = 0; i < 9; i++) cells[i] = 0;
      m_turn = 0; m_busy = 0; m_err = 0; m_over = 0; m_winner = 0;
      m_count = 0; m_left = 0; m_outcome = 0;
   endfunction

   function automatic int first_win(int code);
      for (int l = 0; l < 8; l++)
         if (cells[lines[l][0]] == code && cells[lines[l][1]] == code && cells[lines[l][2]] == code)
            return l;
      return -1;
   endfunction

   function automatic logic [17:0] m_board();
      logic [17:0] b;
      b = '0;
      for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(cells[i]);
      return b;
   endfunction

   initial m_clear();

   always @(posedge ph1) begin
      int code, w, idx;
      if (reset || new_game) begin
         m_clear();
      end else begin
         m_err = 0;
         if (m_busy != 0) begin
            if (move_valid) m_err = 1;
            m_left--;
            if (m_left == 0) begin
               m_busy = 0;
               if (m_outcome == 1) begin
                  m_over = 1; m_winner = (m_turn != 0) ? 2 : 1;
               end else if (m_outcome == 2) begin
                  m_over = 1; m_winner = 3;
               end else begin
                  m_turn = 1 - m_turn;
               end
            end
         end else if (m_over != 0) begin
            if (move_valid) m_err = 1;
         end else if (move_valid) begin
            idx = int'(move_row) * 3 + int'(move_col);
            if (move_row > 2 || move_col > 2 || cells[idx] != 0) begin
               m_err = 1;
            end else begin
               code = (m_turn != 0) ? 2 : 1;
               cells[idx] = code;
               if (m_count < 9) m_count++;
               m_busy = 1;
               w = first_win(code);
               if (w >= 0) begin
                  m_left = w + 1; m_outcome = 1;
               end else begin
                  m_left = 8; m_outcome = (m_count == 9) ? 2 : 0;
               end
            end
         end
      end
   end

   always @(negedge ph1) begin
      if (cmp_en) begin
         checks++;
         if (registers !== m_board() || turn !== 1'(m_turn) || busy !== 1'(m_busy) ||
             move_err !== 1'(m_err) || game_over !== 1'(m_over) || winner !== 2'(m_winner)) begin
            errors++;
            $display("FAIL model_cmp t=%0t got reg=%h turn=%b busy=%b err=%b over=%b win=%b exp reg=%h turn=%0d busy=%0d err=%0d over=%0d win=%0d",
                     $time, registers, turn, busy, move_err, game_over, winner,
                     m_board(), m_turn, m_busy, m_err, m_over, m_winner);
         end
      end
   end

   task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input bit mv, input logic [1:0] r, input logic [1:0] c,
                       input bit ng, input bit rs);
      move_valid = mv; move_row = r; move_col = c; new_game = ng; reset = rs;
      @(posedge ph1);
      #1;
      move_valid = 0; new_game = 0; reset = 0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 12 && busy === 1'b1; i++) step(0, 0, 0, 0, 0);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL wait_idle busy=%b after 12 cycles, expected 0", busy);
      end
   endtask

   task automatic play(input logic [1:0] r, input logic [1:0] c);
      step(1, r, c, 0, 0);
      wait_idle();
   endtask

   logic [1:0] draw_r [9] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
   logic [1:0] draw_c [9] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2};

   initial begin
      repeat (2) @(posedge ph1);
      #1;
      reset = 0;
      cmp_en = 1;
      lit("reset_registers", 32'(registers), 32'h0);
      lit("reset_turn", 32'(turn), 32'h0);
      lit("reset_busy", 32'(busy), 32'h0);
      lit("reset_winner", 32'(winner), 32'h0);

      // first move to centre, full 8-cycle scan, turn passes to O
      step(1, 2'd1, 2'd1, 0, 0);
      lit("centre_registers", 32'(registers), 32'h00100);
      lit("centre_busy", 32'(busy), 32'h1);
      repeat (7) step(0, 0, 0, 0, 0);
      lit("busy_edge7", 32'(busy), 32'h1);
      step(0, 0, 0, 0, 0);
      lit("busy_edge8", 32'(busy), 32'h0);
      lit("turn_flip", 32'(turn), 32'h1);
      lit("no_winner", 32'(winner), 32'h0);

      // rejected requests
      step(1, 2'd1, 2'd1, 0, 0);
      lit("occupied_err", 32'(move_err), 32'h1);
      lit("occupied_reg", 32'(registers), 32'h00100);
      step(0, 0, 0, 0, 0);
      lit("err_one_cycle", 32'(move_err), 32'h0);
      step(1, 2'd3, 2'd0, 0, 0);
      lit("row3_err", 32'(move_err), 32'h1);
      step(1, 2'd0, 2'd3, 0, 0);
      lit("col3_err_b2b", 32'(move_err), 32'h1);
      lit("reject_turn", 32'(turn), 32'h1);

      // X wins on L0 at the first scan cycle
      step(0, 0, 0, 1, 0);
      lit("newgame_reg", 32'(registers), 32'h0);
      play(2'd0, 2'd0); play(2'd1, 2'd0); play(2'd0, 2'd1);
      step(1, 2'd1, 2'd1, 0, 0);
      step(1, 2'd2, 2'd2, 0, 0);
      lit("busy_move_err", 32'(move_err), 32'h1);
      wait_idle();
      step(1, 2'd0, 2'd2, 0, 0);
      lit("win_accept_busy", 32'(busy), 32'h1);
      step(0, 0, 0, 0, 0);
      lit("win_winner", 32'(winner), 32'h1);
      lit("win_over", 32'(game_over), 32'h1);
      lit("win_busy", 32'(busy), 32'h0);
      lit("win_registers", 32'(registers), 32'h00295);
      step(1, 2'd2, 2'd2, 0, 0);
      lit("over_err", 32'(move_err), 32'h1);
      lit("over_reg", 32'(registers), 32'h00295);
      step(1, 2'd2, 2'd2, 1, 0);
      lit("ng_beats_move_reg", 32'(registers), 32'h0);
      lit("ng_turn", 32'(turn), 32'h0);
      lit("ng_over", 32'(game_over), 32'h0);

      // draw
      for (int i = 0; i < 8; i++) play(draw_r[i], draw_c[i]);
      step(1, draw_r[8], draw_c[8], 0, 0);
      repeat (7) step(0, 0, 0, 0, 0);
      lit("draw_pending", 32'(game_over), 32'h0);
      step(0, 0, 0, 0, 0);
      lit("draw_winner", 32'(winner), 32'h3);
      lit("draw_over", 32'(game_over), 32'h1);

      // reset in the middle of a scan (line index 3)
      step(0, 0, 0, 1, 0);
      step(1, 2'd0, 2'd0, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      lit("midscan_reset_reg", 32'(registers), 32'h0);
      lit("midscan_reset_busy", 32'(busy), 32'h0);
      lit("midscan_reset_turn", 32'(turn), 32'h0);
      step(1, 2'd2, 2'd0, 0, 0);
      lit("after_reset_move", 32'(registers), 32'h01000);

      for (int n = 0; n < 4000; n++) begin
         bit mv, ng, rs;
         mv = ($urandom_range(0, 99) < 55);
         ng = ($urandom_range(0, 99) == 0) || (m_over != 0 && $urandom_range(0, 9) == 0);
         rs = ($urandom_range(0, 299) == 0);
         step(mv, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), ng, rs);
      end

      @(negedge ph1);
      cmp_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
